// File: rtl/kb_cmd_ctrl.sv
// PS/2 host-to-keyboard command sequencer: sends Set-LEDs / reset, waits for
// FA/FE/AA/FC replies with timeouts, and filters protocol bytes from the
// received stream.
// Ports: clk, i_sclr | i_led_req, i_leds, i_rst_req | i_byte_en, i_byte ->
//   o_byte_en, o_byte | o_tx_start, o_tx_byte, i_tx_done |
//   o_busy, o_done, o_err, o_err_code.
// Optional: define KBCMD_RETRY_EN to resend a byte up to MAX_RETRY times on FE.
module kb_cmd_ctrl #(
  parameter int TIMEOUT     = 1_000_000,
  parameter int BAT_TIMEOUT = 25_000_000,
  parameter int MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_led_req,
  input  logic [2:0] i_leds,
  input  logic       i_rst_req,
  input  logic       i_byte_en,
  input  logic [7:0] i_byte,
  output logic       o_byte_en,
  output logic [7:0] o_byte,
  output logic       o_tx_start,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_done,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  localparam int CW = $clog2(BAT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, WAIT_TX_CMD, WAIT_ACK_CMD,
    SEND_ARG, WAIT_TX_ARG, WAIT_ACK_ARG, WAIT_BAT
  } state_t;

  state_t        state, nxt, resend;
  logic [CW-1:0] cnt, lim;
  logic          is_rst, rst_sel;
  logic [2:0]    leds;
  logic          accept, fail, nak, done_n;
  logic [1:0]    fail_code;
  logic          expired, consume;
  logic          rx_fa, rx_fe, rx_aa, rx_fc;

  assign rx_fa = i_byte_en && (i_byte == 8'hFA);
  assign rx_fe = i_byte_en && (i_byte == 8'hFE);
  assign rx_aa = i_byte_en && (i_byte == 8'hAA);
  assign rx_fc = i_byte_en && (i_byte == 8'hFC);

  assign lim = (state == WAIT_BAT) ? CW'(BAT_TIMEOUT - 1)
                                   : CW'(TIMEOUT - 1);
  assign expired = (cnt == lim);

  // Protocol replies are swallowed only while a reply is expected.
  assign consume = (state inside {WAIT_ACK_CMD, WAIT_ACK_ARG, WAIT_BAT})
                && (i_byte inside {8'hFA, 8'hFE, 8'hFC, 8'hAA});

  assign o_busy     = (state != IDLE);
  assign o_tx_start = (state == SEND_CMD) || (state == SEND_ARG);

  // On acceptance the command kind is not yet latched.
  assign rst_sel = accept ? i_rst_req : is_rst;

`ifdef KBCMD_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry;

  always_ff @(posedge clk) begin
    if (i_sclr)
      retry <= '0;
    else if (state == IDLE || (state == WAIT_ACK_CMD && nxt == SEND_ARG))
      retry <= '0;
    else if (nak && nxt != IDLE)
      retry <= retry + 1'b1;
  end
`endif

  always_comb begin
    nxt       = state;
    resend    = SEND_CMD;
    accept    = 1'b0;
    fail      = 1'b0;
    fail_code = 2'b01;
    nak       = 1'b0;
    done_n    = 1'b0;
    unique case (state)
      IDLE:
        if (i_rst_req || i_led_req) begin
          accept = 1'b1;
          nxt    = SEND_CMD;
        end
      SEND_CMD: nxt = WAIT_TX_CMD;
      WAIT_TX_CMD:
        if (i_tx_done) nxt = WAIT_ACK_CMD;
        else if (expired) fail = 1'b1;
      WAIT_ACK_CMD:
        if (rx_fa) nxt = is_rst ? WAIT_BAT : SEND_ARG;
        else if (rx_fe) nak = 1'b1;
        else if (expired) fail = 1'b1;
      SEND_ARG: nxt = WAIT_TX_ARG;
      WAIT_TX_ARG:
        if (i_tx_done) nxt = WAIT_ACK_ARG;
        else if (expired) fail = 1'b1;
      WAIT_ACK_ARG:
        if (rx_fa) begin
          done_n = 1'b1;
          nxt    = IDLE;
        end else if (rx_fe) begin
          nak    = 1'b1;
          resend = SEND_ARG;
        end else if (expired) fail = 1'b1;
      WAIT_BAT:
        if (rx_aa) begin
          done_n = 1'b1;
          nxt    = IDLE;
        end else if (rx_fc) begin
          fail      = 1'b1;
          fail_code = 2'b11;
        end else if (expired) fail = 1'b1;
      default: nxt = IDLE;
    endcase
    if (nak) begin
`ifdef KBCMD_RETRY_EN
      if (retry == RW'(MAX_RETRY)) begin
        fail      = 1'b1;
        fail_code = 2'b10;
      end else begin
        nxt = resend;
      end
`else
      fail      = 1'b1;
      fail_code = 2'b10;
`endif
    end
    if (fail) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state      <= IDLE;
      cnt        <= '0;
      is_rst     <= 1'b0;
      leds       <= 3'b000;
      o_tx_byte  <= 8'h00;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= 2'b00;
      o_byte_en  <= 1'b0;
      o_byte     <= 8'h00;
    end else begin
      state <= nxt;
      // Restarts on every state change, so each WAIT state starts at 0.
      cnt <= (nxt != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        is_rst <= i_rst_req;
        leds   <= i_leds;
      end
      if (nxt == SEND_CMD)
        o_tx_byte <= rst_sel ? 8'hFF : 8'hED;
      else if (nxt == SEND_ARG)
        o_tx_byte <= {5'b00000, leds};
      o_done <= done_n;
      o_err  <= fail;
      if (accept) o_err_code <= 2'b00;
      else if (fail) o_err_code <= fail_code;
      o_byte_en <= i_byte_en && !consume;
      if (i_byte_en && !consume) o_byte <= i_byte;
    end
  end

endmodule

// File: doc/kb_cmd_ctrl.md
Name: kb_cmd_ctrl

Overview:
Host-to-keyboard command sequencer for the PS/2 path. It accepts LED-update and keyboard-reset requests, drives a byte transmitter, and waits for the keyboard's acknowledgement bytes, applying timeouts. It sits between the byte receiver and the keydown decoder. It consumes protocol response bytes and forwards all other received bytes unchanged.

Parameters:
TIMEOUT, 1_000_000, max cycles to wait for i_tx_done or for an FA/FE response (20 ms at 50 MHz).
BAT_TIMEOUT, 25_000_000, max cycles to wait for the BAT result after reset is acknowledged (500 ms).
MAX_RETRY, 2, resends per byte on FE (used only with KBCMD_RETRY_EN).

Ports:
clk  in  1  system clock
i_sclr  in  1  synchronous reset, active-high
i_led_req  in  1  one-cycle pulse: send Set-LEDs command
i_leds  in  3  {caps,num,scroll}; sampled when i_led_req is accepted
i_rst_req  in  1  one-cycle pulse: send keyboard reset
i_byte_en  in  1  received-byte strobe from receiver
i_byte  in  8  received byte
o_byte_en  out  1  filtered byte strobe to keydown
o_byte  out  8  filtered byte
o_tx_start  out  1  one-cycle pulse: transmitter loads o_tx_byte
o_tx_byte  out  8  byte to send
i_tx_done  in  1  one-cycle pulse: transmitter finished, device ack-bit seen
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse: command completed successfully
o_err  out  1  one-cycle pulse: command failed
o_err_code  out  2  01 timeout, 10 NAK (FE), 11 BAT fail (FC); held until the next accepted request

Behaviour:
- Reset (i_sclr=1 at a clk edge): state IDLE. All outputs 0, including o_tx_byte and o_err_code. Counters cleared. An in-flight command is abandoned with no o_done or o_err.
- States: IDLE, SEND_CMD, WAIT_TX_CMD, WAIT_ACK_CMD, SEND_ARG, WAIT_TX_ARG, WAIT_ACK_ARG, WAIT_BAT.
- Request acceptance:
  - Requests are accepted only in IDLE.
  - If i_rst_req and i_led_req are both high, i_rst_req wins and i_led_req is dropped.
  - Requests arriving while o_busy=1 are dropped.
  - Acceptance clears o_err_code and latches i_leds.
- SEND_CMD (1 cycle): o_tx_start=1; o_tx_byte = 8'hED (LED) or 8'hFF (reset). Next state WAIT_TX_CMD.
- o_tx_byte stability: o_tx_byte is registered and held stable from the o_tx_start cycle until the next SEND state.
- WAIT_TX_*: on i_tx_done, go to the matching WAIT_ACK_*.
- WAIT_ACK_CMD, on a received byte:
  - FA: for LED go to SEND_ARG; for reset go to WAIT_BAT.
  - FE: NAK handling (see Optional Feature).
- SEND_ARG (1 cycle): o_tx_start=1; o_tx_byte = {5'b0, caps, num, scroll}. Next state WAIT_TX_ARG.
- WAIT_ACK_ARG: FA -> o_done, IDLE. FE -> NAK handling.
- WAIT_BAT: AA -> o_done, IDLE. FC -> o_err, code 11, IDLE.
- Timeout counter:
  - Cleared on entry to every WAIT state.
  - Increments each cycle while in that state.
  - Reaching TIMEOUT-1 (BAT_TIMEOUT-1 in WAIT_BAT) -> o_err, code 01, IDLE.
  - Width is $clog2(BAT_TIMEOUT).
- o_done and o_err are registered. They assert in the cycle after the deciding event, and state is IDLE in that same cycle.
- Byte filter:
  - o_byte_en/o_byte are registered copies of i_byte_en/i_byte, with 1-cycle latency.
  - In WAIT_ACK_* and WAIT_BAT, bytes FA, FE, FC and AA are consumed (o_byte_en=0).
  - All other bytes, and all bytes in other states, are forwarded.
  - o_byte holds its last value when o_byte_en=0.
- Simultaneous events:
  - i_byte_en in the same cycle as i_tx_done in WAIT_TX_*: the byte is forwarded and not interpreted as a response.
  - Timeout expiry in the same cycle as a valid response: the response wins.

Optional Feature:
KBCMD_RETRY_EN.
- Defined: FE in WAIT_ACK_CMD returns to SEND_CMD; FE in WAIT_ACK_ARG returns to SEND_ARG. The same byte is resent. A per-byte retry counter, cleared when a new byte is first sent, allows MAX_RETRY resends. The next FE after that -> o_err, code 10, IDLE.
- Undefined: FE in any WAIT_ACK state -> o_err, code 10, IDLE immediately. MAX_RETRY is ignored and the retry counter is not built.

Test Plan:
- LED path: i_led_req with i_leds=3'b101. Expect o_tx_byte=ED; reply FA; expect o_tx_byte=8'h05; reply FA. Expect one o_done pulse, o_err=0, and neither FA on o_byte_en.
- Reset path: i_rst_req with i_led_req high in the same cycle. Expect FF sent and the LED request dropped. Reply FA then AA -> o_done. Repeat with FC -> o_err, code 11.
- Timeout (TIMEOUT=16): send ED and give i_tx_done, then no reply. Expect o_err with code 01 exactly 16 cycles after entering WAIT_ACK_CMD, then IDLE.
- NAK: reply FE to ED. Without the macro -> o_err, code 10. With the macro (MAX_RETRY=2) -> ED resent twice, third FE -> code 10; or FE, FE, then FA -> proceeds to the arg byte.
- Passthrough/busy: in IDLE, byte 1C -> o_byte_en with o_byte=1C one cycle later. In WAIT_ACK_CMD, byte 1C is forwarded and FA is consumed. i_led_req while busy is ignored.
- Reset mid-op: assert i_sclr in WAIT_ACK_ARG. Expect all outputs 0 next cycle, no o_done or o_err, and a new request accepted right after.
